// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_scan_ctrl : multiplexed 7-segment scanner, frame-buffered BCD value  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+

module seg7_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 1000,
  parameter int GUARD  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic                  blank_lz_i,
  output logic [DIGITS-1:0]     dig_en_o,
  output logic [6:0]            seg_o,
  output logic                  pending_o,
  output logic                  frame_tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } slot_e;

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*DIGITS-1:0]    shadow_q, shadow_d;
  logic [4*DIGITS-1:0]    disp_q, disp_d;
  logic                   pending_q, pending_d;
  logic                   frame_tick_q, frame_tick_d;
  logic [DIGITS-1:0]      dig_en_q, dig_en_d;
  logic [6:0]             seg_q, seg_d;

  slot_e                  slot;
  logic                   wrap;
  logic                   last_digit;
  logic [3:0]             nibble;
  logic                   lz_blank;
  logic [6:0]             dec_seg;

  assign slot       = (cnt_q >= CW'(GUARD)) ? SHOW : BLANK;
  assign wrap       = (cnt_q == CW'(DIV - 1));
  assign last_digit = (idx_q == IW'(DIGITS - 1));
  assign nibble     = 4'(disp_q >> {idx_q, 2'b00});
  // Digit k is a leading zero when it and every higher nibble are zero.
  assign lz_blank   = blank_lz_i && (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);

  bcd_to_7seg u_dec (
    .bcd_i (nibble),
    .seg_o (dec_seg)
  );

  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    disp_d       = disp_q;
    pending_d    = pending_q;
    frame_tick_d = 1'b0;
    dig_en_d     = '0;
    seg_d        = '0;

    if (wrap) begin
      cnt_d = '0;
      idx_d = last_digit ? '0 : idx_q + 1'b1;
    end

    if (wrap && last_digit) begin
      frame_tick_d = 1'b1;
      if (pending_q) begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
      end
    end

    // A load on the commit cycle must win over the pending clear.
    if (load_i) begin
      shadow_d  = value_i;
      pending_d = 1'b1;
    end

    if (slot == SHOW) begin
      dig_en_d = DIGITS'(1) << idx_q;
      seg_d    = lz_blank ? 7'b0000000 : dec_seg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      dig_en_q     <= '0;
      seg_q        <= '0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      dig_en_q     <= dig_en_d;
      seg_q        <= seg_d;
    end
  end

  assign dig_en_o     = dig_en_q;
  assign seg_o        = seg_q;
  assign pending_o    = pending_q;
  assign frame_tick_o = frame_tick_q;

endmodule

// Segment order {a,b,c,d,e,f,g}; non-BCD nibbles decode to all-off.
module bcd_to_7seg (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b0000000;
    case (bcd_i)
      4'd0: seg_o = 7'b1111110;
      4'd1: seg_o = 7'b0110000;
      4'd2: seg_o = 7'b1101101;
      4'd3: seg_o = 7'b1111001;
      4'd4: seg_o = 7'b0110011;
      4'd5: seg_o = 7'b1011011;
      4'd6: seg_o = 7'b1011111;
      4'd7: seg_o = 7'b1110000;
      4'd8: seg_o = 7'b1111111;
      4'd9: seg_o = 7'b1111011;
      default: seg_o = 7'b0000000;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seg7_scan_ctrl : directed + random bench with a frame-level model      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+

module tb_seg7_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int GUARD  = 2;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  dig_en;
  logic [6:0]  seg;
  logic        pending;
  logic        frame_tick;

  int n_cmp  = 0;
  int n_fail = 0;

  seg7_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_i       (load),
    .value_i      (value),
    .blank_lz_i   (blank_lz),
    .dig_en_o     (dig_en),
    .seg_o        (seg),
    .pending_o    (pending),
    .frame_tick_o (frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] font [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011};

  // Model: n counts clock edges since reset; slot and phase follow by division.
  int          m_n = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_disp = '0;
  logic        m_pend = 1'b0;
  logic [3:0]  e_dig = '0;
  logic [6:0]  e_seg = '0;
  logic        e_pend = 1'b0;
  logic        e_tick = 1'b0;

  task automatic model_edge(input logic r, input logic ld, input logic [15:0] v,
                            input logic blz);
    int phase, d, nib;
    logic blanked;
    if (r) begin
      m_n = 0; m_shadow = '0; m_disp = '0; m_pend = 1'b0;
      e_dig = '0; e_seg = '0; e_tick = 1'b0;
    end else begin
      phase = m_n % DIV;
      d     = (m_n / DIV) % DIGITS;
      e_dig = '0;
      e_seg = '0;
      if (phase >= GUARD) begin
        e_dig   = 4'(1 << d);
        nib     = int'((m_disp >> (4 * d)) & 16'hF);
        blanked = blz && (d > 0) && ((m_disp >> (4 * d)) == 0);
        e_seg   = (nib > 9 || blanked) ? 7'b0 : font[nib];
      end
      e_tick = ((m_n % FRAME) == FRAME - 1);
      if (e_tick && m_pend) begin
        m_disp = m_shadow;
        m_pend = 1'b0;
      end
      if (ld) begin
        m_shadow = v;
        m_pend   = 1'b1;
      end
      m_n++;
    end
    e_pend = m_pend;
  endtask

  task automatic check_all();
    n_cmp++;
    assert (dig_en === e_dig) else begin
      n_fail++; $error("FAIL dig_en got=%b want=%b t=%0t", dig_en, e_dig, $time);
    end
    n_cmp++;
    assert (seg === e_seg) else begin
      n_fail++; $error("FAIL seg got=%b want=%b t=%0t", seg, e_seg, $time);
    end
    n_cmp++;
    assert (pending === e_pend) else begin
      n_fail++; $error("FAIL pending got=%b want=%b t=%0t", pending, e_pend, $time);
    end
    n_cmp++;
    assert (frame_tick === e_tick) else begin
      n_fail++; $error("FAIL frame_tick got=%b want=%b t=%0t", frame_tick, e_tick, $time);
    end
  endtask

  // Drive inputs at the falling edge, clock once, check at the next falling edge.
  task automatic cyc(input logic r, input logic ld, input logic [15:0] v);
    rst = r; load = ld; value = v;
    @(posedge clk);
    model_edge(r, ld, v, blank_lz);
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0);
  endtask

  task automatic run_to_phase(input int p);
    int guard_cnt;
    guard_cnt = 0;
    while ((m_n % FRAME) != p && guard_cnt < 2 * FRAME) begin
      cyc(1'b0, 1'b0, 16'h0);
      guard_cnt++;
    end
  endtask

  // Wait until the DUT shows digit d, then compare its segments to a constant.
  task automatic expect_digit(input int d, input logic [6:0] want, input string tag);
    int k;
    k = 0;
    while (dig_en !== 4'(1 << d) && k < 2 * FRAME) begin
      cyc(1'b0, 1'b0, 16'h0);
      k++;
    end
    n_cmp++;
    assert (dig_en === 4'(1 << d) && seg === want) else begin
      n_fail++; $error("FAIL %s dig_en=%b seg got=%b want=%b", tag, dig_en, seg, want);
    end
  endtask

  initial begin
    @(negedge clk);
    cyc(1'b1, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 16'h0);
    n_cmp++;
    assert (dig_en === 4'b0 && seg === 7'b0 && pending === 1'b0 && frame_tick === 1'b0)
      else begin
        n_fail++; $error("FAIL reset_state dig=%b seg=%b pend=%b tick=%b want all 0",
                         dig_en, seg, pending, frame_tick);
      end

    // Idle scan: zero value on every digit.
    blank_lz = 1'b0;
    run(2 * FRAME + 3);
    expect_digit(2, 7'b1111110, "idle_d2");

    // Buffered load mid-frame.
    run_to_phase(13);
    cyc(1'b0, 1'b1, 16'h1234);
    expect_digit(3, 7'b1111110, "pre_commit_d3");
    run_to_phase(0);
    expect_digit(0, 7'b0110011, "1234_d0");
    expect_digit(1, 7'b1111001, "1234_d1");
    expect_digit(2, 7'b1101101, "1234_d2");
    expect_digit(3, 7'b0110000, "1234_d3");

    // Leading-zero blanking.
    blank_lz = 1'b1;
    cyc(1'b0, 1'b1, 16'h0070);
    run_to_phase(0);
    expect_digit(0, 7'b1111110, "lz_d0");
    expect_digit(1, 7'b1110000, "lz_d1");
    expect_digit(2, 7'b0000000, "lz_d2");
    expect_digit(3, 7'b0000000, "lz_d3");
    cyc(1'b0, 1'b1, 16'h0000);
    run_to_phase(0);
    expect_digit(0, 7'b1111110, "zero_d0");
    expect_digit(1, 7'b0000000, "zero_d1");

    // Invalid nibble.
    blank_lz = 1'b0;
    cyc(1'b0, 1'b1, 16'h9A05);
    run_to_phase(0);
    expect_digit(0, 7'b1011011, "inv_d0");
    expect_digit(1, 7'b1111110, "inv_d1");
    expect_digit(2, 7'b0000000, "inv_d2");
    expect_digit(3, 7'b1111011, "inv_d3");

    // Load landing exactly on the commit cycle.
    run_to_phase(5);
    cyc(1'b0, 1'b1, 16'h2222);
    run_to_phase(FRAME - 1);
    cyc(1'b0, 1'b1, 16'h1111);
    n_cmp++;
    assert (pending === 1'b1 && frame_tick === 1'b1) else begin
      n_fail++; $error("FAIL commit_load pend=%b tick=%b want 1/1", pending, frame_tick);
    end
    expect_digit(1, 7'b1101101, "2222_d1");
    run_to_phase(0);
    expect_digit(1, 7'b0110000, "1111_d1");

    // Reset during digit 2 SHOW with a value pending.
    cyc(1'b0, 1'b1, 16'h5678);
    expect_digit(2, 7'b0110000, "pre_rst_d2");
    cyc(1'b1, 1'b0, 16'h0);
    n_cmp++;
    assert (dig_en === 4'b0 && seg === 7'b0 && pending === 1'b0) else begin
      n_fail++; $error("FAIL mid_reset dig=%b seg=%b pend=%b want 0", dig_en, seg, pending);
    end
    run(GUARD + 1);
    n_cmp++;
    assert (dig_en === 4'b0001 && seg === 7'b1111110) else begin
      n_fail++; $error("FAIL post_reset dig=%b seg=%b want 0001/1111110", dig_en, seg);
    end

    // Randomized traffic against the frame model.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] v;
      for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom % 12);
      if ($urandom % 3 == 0) v[15:8] = 8'h00;
      if ($urandom % 40 == 0) blank_lz = ~blank_lz;
      cyc(($urandom % 400) == 0, ($urandom % 15) == 0, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
